xbus_arbiter_fabric: RTL and testbench

Parametrised xbus interconnect between the core (single master) and `NSLAVES` memory-mapped slaves. It replaces the fixed combinational chip-select and read-data mux with a registered transfer engine that supports:

- a per-slave address map,
- slave wait states through a `ready` handshake,
- an error response for unmapped addresses,
- an optional watchdog that aborts transfers to slaves that never respond.

It sits at SoC top level between the core's xbus master port and the rom/ram/sw_led slaves.

---
 rtl/xbus_arbiter_fabric_pkg.sv | 31 +++
 rtl/xbus_arbiter_fabric_if.sv | 43 ++++
 rtl/xbus_map_decode.sv | 27 ++
 rtl/xbus_arbiter_fabric.sv | 124 ++++++++++++
 tb/tb_xbus_arbiter_fabric.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xbus_arbiter_fabric_pkg.sv
// Shared types and constants for the xbus interconnect fabric.
// Holds the default slave map, the transfer FSM state encoding, the
// read value returned on an error response and the latched request payload.
package xbus_arbiter_fabric_pkg;

    localparam int unsigned DEF_NSLAVES = 4;
    localparam int unsigned XBUS_DW     = 32;
    localparam int unsigned XBUS_BEW    = 4;
    localparam int unsigned XBUS_CNTW   = 8;

    // Slave i occupies bits [32i+31:32i]; slave 0 sits at 0x1000.
    localparam logic [DEF_NSLAVES*32-1:0] DEF_ADDR_BASE =
        {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    localparam logic [DEF_NSLAVES*32-1:0] DEF_ADDR_MASK = {DEF_NSLAVES{32'hFFFF_F000}};

    localparam logic [XBUS_DW-1:0] ERR_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        XBUS_ST_IDLE   = 2'd0,
        XBUS_ST_ACCESS = 2'd1,
        XBUS_ST_ERROR  = 2'd2
    } xbus_state_e;

    typedef struct packed {
        logic                we;
        logic [XBUS_BEW-1:0] be;
        logic [XBUS_DW-1:0]  addr;
        logic [XBUS_DW-1:0]  wdata;
    } xbus_req_t;

endpackage

// File: rtl/xbus_arbiter_fabric_if.sv
// Bundles the core-side master port and the broadcast slave port of the fabric.
// Modports:
//   master - the surrounding system: the core drives m_as/m_we/m_be/m_addr/m_wdata
//            and the slaves drive s_rdata/s_ready; it observes everything else.
//   slave  - the fabric itself, which is the xbus slave of the core and the
//            master of the memory-mapped slaves.
interface xbus_arbiter_fabric_if
    import xbus_arbiter_fabric_pkg::*;
#(
    parameter int unsigned NSLAVES = DEF_NSLAVES
);
    logic                      m_as;
    logic                      m_we;
    logic [XBUS_BEW-1:0]       m_be;
    logic [XBUS_DW-1:0]        m_addr;
    logic [XBUS_DW-1:0]        m_wdata;
    logic [XBUS_DW-1:0]        m_rdata;
    logic                      m_ready;
    logic                      m_err;

    logic [NSLAVES-1:0]        s_cs;
    logic                      s_we;
    logic [XBUS_BEW-1:0]       s_be;
    logic [XBUS_DW-1:0]        s_addr;
    logic [XBUS_DW-1:0]        s_wdata;
    logic [NSLAVES*XBUS_DW-1:0] s_rdata;
    logic [NSLAVES-1:0]        s_ready;

    modport master (
        output m_as, m_we, m_be, m_addr, m_wdata,
        input  m_rdata, m_ready, m_err,
        input  s_cs, s_we, s_be, s_addr, s_wdata,
        output s_rdata, s_ready
    );

    modport slave (
        input  m_as, m_we, m_be, m_addr, m_wdata,
        output m_rdata, m_ready, m_err,
        output s_cs, s_we, s_be, s_addr, s_wdata,
        input  s_rdata, s_ready
    );

endinterface

// File: rtl/xbus_map_decode.sv
// Combinational address decoder for the xbus slave map.
// Ports: addr - request address; base/mask - packed per-slave map (slave i at
// [32i+31:32i]); hit - some slave matches; idx - lowest matching slave index.
module xbus_map_decode #(
    parameter int unsigned NSLAVES = 4,
    parameter int unsigned IDX_W   = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
    input  logic [31:0]           addr,
    input  logic [NSLAVES*32-1:0] base,
    input  logic [NSLAVES*32-1:0] mask,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    // Scan from the top so the lowest matching index is written last and wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(NSLAVES) - 1; i >= 0; i--) begin
            if ((addr & mask[32*i +: 32]) == base[32*i +: 32]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/xbus_arbiter_fabric.sv
// Registered xbus transfer engine between one master and NSLAVES slaves.
// Accepts a request in IDLE, selects the decoded slave in ACCESS until its
// s_ready, and answers unmapped addresses with a one-cycle error response.
// Ports: clk; rst (async, active low); bus (slave modport of xbus_arbiter_fabric_if).
// Build option: define XBUS_TIMEOUT_EN to add the wait watchdog (TIMEOUT param)
// that aborts an ACCESS to a silent slave with an error response.
// m_ready/m_err/m_rdata are decoded from the state register and the selected
// slave's s_ready/s_rdata so a zero-wait slave completes in its select cycle.
module xbus_arbiter_fabric
    import xbus_arbiter_fabric_pkg::*;
#(
    parameter int unsigned           NSLAVES   = DEF_NSLAVES,
    parameter logic [NSLAVES*32-1:0] ADDR_BASE = DEF_ADDR_BASE,
    parameter logic [NSLAVES*32-1:0] ADDR_MASK = DEF_ADDR_MASK
`ifdef XBUS_TIMEOUT_EN
    ,
    parameter int unsigned           TIMEOUT   = 15
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    xbus_arbiter_fabric_if.slave bus
);

    localparam int unsigned IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    xbus_state_e        state;
    xbus_req_t          req_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NSLAVES-1:0] cs_q;

    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic               sel_ready;
    logic [XBUS_DW-1:0] sel_rdata;
    logic               done_ok;

`ifdef XBUS_TIMEOUT_EN
    localparam logic [XBUS_CNTW-1:0] TIMEOUT_W = XBUS_CNTW'(TIMEOUT);
    logic [XBUS_CNTW-1:0] wait_cnt;
`endif

    xbus_map_decode #(
        .NSLAVES (NSLAVES),
        .IDX_W   (IDX_W)
    ) u_decode (
        .addr (bus.m_addr),
        .base (ADDR_BASE),
        .mask (ADDR_MASK),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Only the latched slave's handshake is looked at.
    assign sel_ready = bus.s_ready[idx_q];
    assign sel_rdata = bus.s_rdata[32*int'(idx_q) +: 32];

    // Transfer FSM with latched request, slave select and optional watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= XBUS_ST_IDLE;
            req_q <= '0;
            idx_q <= '0;
            cs_q  <= '0;
`ifdef XBUS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            unique case (state)
                XBUS_ST_IDLE: begin
                    if (bus.m_as) begin
                        req_q <= '{we: bus.m_we, be: bus.m_be, addr: bus.m_addr, wdata: bus.m_wdata};
                        if (dec_hit) begin
                            idx_q <= dec_idx;
                            cs_q  <= NSLAVES'(1) << dec_idx;
                            state <= XBUS_ST_ACCESS;
`ifdef XBUS_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end else begin
                            state <= XBUS_ST_ERROR;
                        end
                    end
                end
                XBUS_ST_ACCESS: begin
                    // A late s_ready still beats the watchdog in the same cycle.
                    if (sel_ready) begin
                        cs_q  <= '0;
                        state <= XBUS_ST_IDLE;
                    end
`ifdef XBUS_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_W) begin
                        cs_q  <= '0;
                        state <= XBUS_ST_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + XBUS_CNTW'(1);
                    end
`endif
                end
                XBUS_ST_ERROR: begin
                    state <= XBUS_ST_IDLE;
                end
                default: begin
                    cs_q  <= '0;
                    state <= XBUS_ST_IDLE;
                end
            endcase
        end
    end

    assign done_ok = (state == XBUS_ST_ACCESS) && sel_ready;

    assign bus.s_cs    = cs_q;
    assign bus.s_we    = req_q.we;
    assign bus.s_be    = req_q.be;
    assign bus.s_addr  = req_q.addr;
    assign bus.s_wdata = req_q.wdata;

    // Error responses and non-completion cycles both return ERR_RDATA (zero).
    assign bus.m_ready = done_ok || (state == XBUS_ST_ERROR);
    assign bus.m_err   = (state == XBUS_ST_ERROR);
    assign bus.m_rdata = done_ok ? sel_rdata : ERR_RDATA;

endmodule

// File: tb/tb_xbus_arbiter_fabric.sv
// Self-checking bench for xbus_arbiter_fabric: a driver issues transfers with
// per-cycle timing checks and pushes the expected response into a scoreboard;
// a monitor pops and compares on every m_ready.
module tb_xbus_arbiter_fabric;

    localparam int unsigned NS = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    xbus_arbiter_fabric_if #(.NSLAVES(NS)) bus ();

    xbus_arbiter_fabric #(.NSLAVES(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave sl returns rd; every other slave returns a distinct junk word.
    task automatic load_rdata(input int sl, input logic [31:0] rd);
        for (int i = 0; i < int'(NS); i++)
            bus.s_rdata[32*i +: 32] = (i == sl) ? rd : (32'hBAD0_0000 | 32'(i));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.m_as    = 1'b0;
            bus.s_ready = '0;
            #1;
            check("idle_rdy", 32'(bus.m_ready), 32'd0);
            check("idle_cs", 32'(bus.s_cs), 32'd0);
        end
    endtask

    // sl < 0 means unmapped; slave ready after 'waits' wait cycles.
    task automatic run_xfer(input string tag, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int sl, input int waits, input logic [31:0] rd,
                            input bit drop_as);
        logic [NS-1:0] sel;
        bit miss;
        int last;
        miss = (sl < 0);
        sel  = '0;
        if (!miss) sel[sl] = 1'b1;
        last = miss ? 1 : waits + 1;
        @(negedge clk);
        bus.m_as = 1'b1; bus.m_we = we; bus.m_be = be;
        bus.m_addr = addr; bus.m_wdata = wdata;
        bus.s_ready = '0;
        load_rdata(sl, rd);
        sb_q.push_back('{rdata: miss ? 32'h0 : rd, err: miss});
        #1;
        check({tag, "_c0_rdy"}, 32'(bus.m_ready), 32'd0);
        check({tag, "_c0_cs"}, 32'(bus.s_cs), 32'd0);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (drop_as && c == 1) begin
                bus.m_as = 1'b0; bus.m_we = ~we; bus.m_be = ~be;
                bus.m_addr = ~addr; bus.m_wdata = ~wdata;
            end
            // Unselected slaves claim ready throughout; they must be ignored.
            bus.s_ready = (c == last) ? '1 : ~sel;
            #1;
            check({tag, "_cs"}, 32'(bus.s_cs), 32'(sel));
            check({tag, "_rdy"}, 32'(bus.m_ready), (c == last) ? 32'd1 : 32'd0);
            if (!miss) begin
                check({tag, "_s_we"}, 32'(bus.s_we), 32'(we));
                check({tag, "_s_be"}, 32'(bus.s_be), 32'(be));
                check({tag, "_s_addr"}, bus.s_addr, addr);
                check({tag, "_s_wdata"}, bus.s_wdata, wdata);
            end
        end
    endtask

`ifdef XBUS_TIMEOUT_EN
    task automatic run_timeout();
        @(negedge clk);
        bus.m_as = 1'b1; bus.m_we = 1'b0; bus.m_be = 4'hF;
        bus.m_addr = 32'h0000_1000; bus.m_wdata = 32'h0;
        bus.s_ready = '0;
        load_rdata(0, 32'h1111_0000);
        sb_q.push_back('{rdata: 32'h0, err: 1'b1});
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            bus.s_ready = 4'b1110;
            #1;
            check("wd_cs", 32'(bus.s_cs), 32'd1);
            check("wd_rdy", 32'(bus.m_ready), 32'd0);
        end
        @(negedge clk);
        #1;
        check("wd_abort_cs", 32'(bus.s_cs), 32'd0);
        check("wd_abort_rdy", 32'(bus.m_ready), 32'd1);
        check("wd_abort_err", 32'(bus.m_err), 32'd1);
    endtask
`endif

    // Scoreboard monitor: every completion must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (bus.m_ready) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_rdy", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_rdata", bus.m_rdata, e.rdata);
                        check("sb_err", 32'(bus.m_err), 32'(e.err));
                    end
                end else begin
                    check("quiet_out", {bus.m_rdata[31:1], bus.m_rdata[0] | bus.m_err}, 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int sl;
        int w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic we;
        bit drop;

        bus.m_as = 1'b0; bus.m_we = 1'b0; bus.m_be = '0;
        bus.m_addr = '0; bus.m_wdata = '0;
        bus.s_rdata = '0; bus.s_ready = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_cs", 32'(bus.s_cs), 32'd0);
        check("rst_rdy", 32'(bus.m_ready), 32'd0);
        check("rst_err", 32'(bus.m_err), 32'd0);
        check("rst_rdata", bus.m_rdata, 32'd0);
        check("rst_s_addr", bus.s_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        run_xfer("rd0", 1'b0, 4'hF, 32'h0000_2004, 32'h0, 1, 0, 32'hCAFE_0001, 1'b0);
        idle(1);
        run_xfer("wr3", 1'b1, 4'b0001, 32'h0000_3000, 32'h0000_00A5, 2, 3, 32'h5555_0002, 1'b0);
        idle(1);
        run_xfer("miss", 1'b0, 4'hF, 32'h0000_8000, 32'h0, -1, 0, 32'h7777_7777, 1'b0);
        idle(1);

        // Back-to-back with m_as held: second transfer accepted right after m_ready.
        run_xfer("b2b_a", 1'b0, 4'hF, 32'h0000_1FFC, 32'h0, 0, 0, 32'h0A0A_0000, 1'b0);
        run_xfer("b2b_b", 1'b1, 4'hF, 32'h0000_4ABC, 32'h1357_9BDF, 3, 1, 32'h0B0B_0003, 1'b0);
        idle(1);

        // Master drops m_as and scrambles fields after acceptance.
        run_xfer("drop", 1'b1, 4'b1100, 32'h0000_2010, 32'h1234_5678, 1, 2, 32'h2222_0001, 1'b1);
        run_xfer("drop_nx", 1'b0, 4'hF, 32'h0000_3FF0, 32'h0, 2, 0, 32'h3333_0002, 1'b0);
        idle(1);

        // Ready in the cycle the wait count reaches 15 completes normally.
        run_xfer("wait15", 1'b0, 4'hF, 32'h0000_1000, 32'h0, 0, 15, 32'hF00D_0015, 1'b0);
        idle(1);
`ifdef XBUS_TIMEOUT_EN
        run_timeout();
`else
        run_xfer("wait20", 1'b0, 4'hF, 32'h0000_1000, 32'h0, 0, 20, 32'hF00D_0020, 1'b0);
`endif
        idle(1);

        // Reset during a wait: no response, latched fields cleared.
        @(negedge clk);
        bus.m_as = 1'b1; bus.m_we = 1'b1; bus.m_be = 4'hF;
        bus.m_addr = 32'h0000_2008; bus.m_wdata = 32'hDEAD_BEEF;
        bus.s_ready = '0;
        @(negedge clk);
        bus.m_as = 1'b0;
        #1;
        check("rstm_cs_before", 32'(bus.s_cs), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstm_cs", 32'(bus.s_cs), 32'd0);
        check("rstm_rdy", 32'(bus.m_ready), 32'd0);
        check("rstm_s_addr", bus.s_addr, 32'd0);
        check("rstm_s_wdata", bus.s_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        run_xfer("post_rst", 1'b0, 4'hF, 32'h0000_2004, 32'h0, 1, 1, 32'hCAFE_0002, 1'b0);
        idle(1);

        // Mixed random traffic, including unmapped addresses.
        for (int n = 0; n < 24; n++) begin
            sl   = int'($urandom_range(0, 4));
            w    = int'($urandom_range(0, 3));
            we   = 1'($urandom_range(0, 1));
            d    = $urandom;
            rd   = $urandom;
            drop = (w > 0) && ($urandom_range(0, 1) == 1);
            if (sl == 4) begin
                a  = 32'h0000_5000 | 32'($urandom_range(0, 4095));
                sl = -1;
                w  = 0;
            end else begin
                a = 32'((sl + 1) << 12) | 32'($urandom_range(0, 4095));
            end
            run_xfer("rnd", we, 4'($urandom_range(0, 15)), a, d, sl, w, rd, drop);
            if ($urandom_range(0, 1) == 1) idle(1);
        end

        idle(3);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
